gb_ppu_timing: RTL and testbench

//  Parametrised PPU line/frame timing engine. Owns the dot counter, LY, PPU mode FSM, LYC compare,

---
 rtl/gb_ppu_timing_pkg.sv | 33 +++
 rtl/gb_ppu_timing_if.sv | 31 +++
 rtl/gb_ppu_stat_irq.sv | 46 ++++
 rtl/gb_ppu_timing.sv | 131 +++++++++++++
 tb/tb_gb_ppu_timing.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/gb_ppu_timing_pkg.sv
// Shared types and DMG timing constants for the PPU timing engine.
package gb_ppu_timing_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK   = 2'd0,
        MODE_VBLANK   = 2'd1,
        MODE_OAM_SCAN = 2'd2,
        MODE_DRAWING  = 2'd3
    } ppu_mode_state_t;

    localparam int DMG_DOTS_PER_LINE  = 456;
    localparam int DMG_VISIBLE_LINES  = 144;
    localparam int DMG_TOTAL_LINES    = 154;
    localparam int DMG_OAM_SCAN_DOTS  = 80;
    localparam int DMG_MODE3_MAX_DOTS = 289;

    // STAT[6:3] interrupt source enables
    typedef struct packed {
        logic lyc;
        logic mode2;
        logic mode1;
        logic mode0;
    } stat_enables_t;

    // OR of every enabled STAT interrupt source
    function automatic logic stat_line_of(stat_enables_t en, logic lyc_eq, ppu_mode_state_t mode);
        return (en.lyc   & lyc_eq) |
               (en.mode2 & (mode == MODE_OAM_SCAN)) |
               (en.mode1 & (mode == MODE_VBLANK)) |
               (en.mode0 & (mode == MODE_HBLANK));
    endfunction

endpackage

// File: rtl/gb_ppu_timing_if.sv
// Control/status bundle between the CPU-facing side and the PPU timing engine.
interface gb_ppu_timing_if #(
    parameter int LY_W  = 8,
    parameter int DOT_W = 9
);
    logic              lcd_en;
    logic              stat_wr;
    logic [3:0]        stat_wdata;
    logic              lyc_wr;
    logic [LY_W-1:0]   lyc_wdata;
    logic              mode3_done;

    logic [1:0]        ppu_mode;
    logic [LY_W-1:0]   ly;
    logic [DOT_W-1:0]  dot;
    logic [7:0]        stat_rd;
    logic              lyc_eq;
    logic              line_start;
    logic              irq_vblank;
    logic              irq_stat;

    modport master (
        output lcd_en, stat_wr, stat_wdata, lyc_wr, lyc_wdata, mode3_done,
        input  ppu_mode, ly, dot, stat_rd, lyc_eq, line_start, irq_vblank, irq_stat
    );

    modport slave (
        input  lcd_en, stat_wr, stat_wdata, lyc_wr, lyc_wdata, mode3_done,
        output ppu_mode, ly, dot, stat_rd, lyc_eq, line_start, irq_vblank, irq_stat
    );
endinterface

// File: rtl/gb_ppu_stat_irq.sv
// STAT interrupt line combine and rising-edge detect (STAT blocking).
// Build option STAT_WRITE_BUG_EN: a STAT write during HBLANK/VBLANK or while
// LY==LYC briefly sees all enables set, as on original DMG hardware.
module gb_ppu_stat_irq
    import gb_ppu_timing_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_active,
    input  logic            i_lcd_en,
`ifdef STAT_WRITE_BUG_EN
    input  logic            i_stat_wr,
`endif
    input  stat_enables_t   i_en,
    input  logic            i_lyc_eq,
    input  ppu_mode_state_t i_mode,
    output logic            o_irq_stat
);

    stat_enables_t w_en_eff;
    logic          w_stat_line;
    logic          r_stat_line_q;

`ifdef STAT_WRITE_BUG_EN
    logic w_wr_bug;
    assign w_wr_bug = i_active & i_lcd_en & i_stat_wr &
                      ((i_mode == MODE_HBLANK) | (i_mode == MODE_VBLANK) | i_lyc_eq);
    assign w_en_eff = w_wr_bug ? stat_enables_t'(4'hF) : i_en;
`else
    assign w_en_eff = i_en;
`endif

    // The line only exists while the timing engine is running
    assign w_stat_line = i_active & stat_line_of(w_en_eff, i_lyc_eq, i_mode);
    assign o_irq_stat  = w_stat_line & ~r_stat_line_q;

    // Remember the previous line level; cleared whenever the LCD is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_line_q <= 1'b0;
        end else begin
            r_stat_line_q <= i_lcd_en ? w_stat_line : 1'b0;
        end
    end

endmodule

// File: rtl/gb_ppu_timing.sv
// PPU line/frame timing engine: dot/LY counters, mode FSM, STAT/LYC
// registers, VBlank and STAT interrupts. Defaults give DMG timing.
// Build option STAT_WRITE_BUG_EN enables the DMG STAT-write spurious IRQ.
module gb_ppu_timing
    import gb_ppu_timing_pkg::*;
#(
    parameter int DOTS_PER_LINE  = DMG_DOTS_PER_LINE,
    parameter int VISIBLE_LINES  = DMG_VISIBLE_LINES,
    parameter int TOTAL_LINES    = DMG_TOTAL_LINES,
    parameter int OAM_SCAN_DOTS  = DMG_OAM_SCAN_DOTS,
    parameter int MODE3_MAX_DOTS = DMG_MODE3_MAX_DOTS,
    parameter int LY_W           = 8
)(
    input  logic           clk,
    input  logic           reset,
    gb_ppu_timing_if.slave bus
);

    localparam int DOT_W = $clog2(DOTS_PER_LINE);

    localparam logic [DOT_W-1:0] LAST_DOT   = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DRAW_DOT   = DOT_W'(OAM_SCAN_DOTS);
    localparam logic [DOT_W-1:0] M3_END_DOT = DOT_W'(OAM_SCAN_DOTS + MODE3_MAX_DOTS - 1);
    localparam logic [LY_W-1:0]  LAST_LY    = LY_W'(TOTAL_LINES - 1);
    localparam logic [LY_W-1:0]  VBLANK_LY  = LY_W'(VISIBLE_LINES);

    logic [DOT_W-1:0] r_dot;
    logic [LY_W-1:0]  r_ly;
    ppu_mode_state_t  r_mode;
    logic             r_active;
    logic             r_line_start;
    logic             r_irq_vblank;
    stat_enables_t    r_en;
    logic [LY_W-1:0]  r_lyc;

    logic             w_dot_wrap;
    logic [DOT_W-1:0] w_dot_nxt;
    logic [LY_W-1:0]  w_ly_nxt;
    logic             w_lyc_eq;
    logic             w_irq_stat;

    // Next-position arithmetic for the free-running dot/line counters
    always_comb begin
        w_dot_wrap = (r_dot == LAST_DOT);
        w_dot_nxt  = w_dot_wrap ? '0 : r_dot + 1'b1;
        w_ly_nxt   = r_ly;
        if (w_dot_wrap) begin
            w_ly_nxt = (r_ly == LAST_LY) ? '0 : r_ly + 1'b1;
        end
    end

    // Mode FSM with counters and registered line_start/irq_vblank pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dot        <= '0;
            r_ly         <= '0;
            r_mode       <= MODE_HBLANK;
            r_active     <= 1'b0;
            r_line_start <= 1'b0;
            r_irq_vblank <= 1'b0;
        end else if (!bus.lcd_en) begin
            r_dot        <= '0;
            r_ly         <= '0;
            r_mode       <= MODE_HBLANK;
            r_active     <= 1'b0;
            r_line_start <= 1'b0;
            r_irq_vblank <= 1'b0;
        end else if (!r_active) begin
            // first enabled cycle always starts a fresh frame
            r_dot        <= '0;
            r_ly         <= '0;
            r_mode       <= MODE_OAM_SCAN;
            r_active     <= 1'b1;
            r_line_start <= 1'b1;
            r_irq_vblank <= 1'b0;
        end else begin
            r_dot        <= w_dot_nxt;
            r_ly         <= w_ly_nxt;
            r_line_start <= w_dot_wrap;
            r_irq_vblank <= w_dot_wrap && (w_ly_nxt == VBLANK_LY);
            if (w_ly_nxt >= VBLANK_LY) begin
                r_mode <= MODE_VBLANK;
            end else if (w_dot_wrap) begin
                r_mode <= MODE_OAM_SCAN;
            end else begin
                case (r_mode)
                    MODE_OAM_SCAN: if (w_dot_nxt == DRAW_DOT) r_mode <= MODE_DRAWING;
                    MODE_DRAWING:  if (bus.mode3_done || (r_dot == M3_END_DOT)) r_mode <= MODE_HBLANK;
                    default:       r_mode <= r_mode;
                endcase
            end
        end
    end

    // CPU writes to STAT enables and LYC; accepted even with the LCD off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en  <= '0;
            r_lyc <= '0;
        end else begin
            if (bus.stat_wr) r_en  <= stat_enables_t'(bus.stat_wdata);
            if (bus.lyc_wr)  r_lyc <= bus.lyc_wdata;
        end
    end

    assign w_lyc_eq = (r_ly == r_lyc);

    gb_ppu_stat_irq u_stat_irq (
        .clk        (clk),
        .reset      (reset),
        .i_active   (r_active),
        .i_lcd_en   (bus.lcd_en),
`ifdef STAT_WRITE_BUG_EN
        .i_stat_wr  (bus.stat_wr),
`endif
        .i_en       (r_en),
        .i_lyc_eq   (w_lyc_eq),
        .i_mode     (r_mode),
        .o_irq_stat (w_irq_stat)
    );

    assign bus.ppu_mode   = r_mode;
    assign bus.ly         = r_ly;
    assign bus.dot        = r_dot;
    assign bus.stat_rd    = {1'b1, r_en, w_lyc_eq, r_mode};
    assign bus.lyc_eq     = w_lyc_eq;
    assign bus.line_start = r_line_start;
    assign bus.irq_vblank = r_irq_vblank;
    assign bus.irq_stat   = w_irq_stat;

endmodule

// File: tb/tb_gb_ppu_timing.sv
// Directed bench for gb_ppu_timing with DMG default parameters.
module tb_gb_ppu_timing;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    gb_ppu_timing_if #(.LY_W(8), .DOT_W(9)) bus ();

    gb_ppu_timing dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_to(input int l, input int d);
        int n = 0;
        while (!(bus.ly == l && bus.dot == d) && n < 80000) begin
            tick();
            n++;
        end
        chk($sformatf("reach_ly%0d_dot%0d", l, d), {31'd0, n < 80000}, 32'd1);
    endtask

    initial begin
        int cnt;
        logic exp_bug;
`ifdef STAT_WRITE_BUG_EN
        exp_bug = 1'b1;
`else
        exp_bug = 1'b0;
`endif
        reset = 1'b1;
        bus.lcd_en = 1'b0; bus.stat_wr = 1'b0; bus.stat_wdata = 4'h0;
        bus.lyc_wr = 1'b0; bus.lyc_wdata = 8'h00; bus.mode3_done = 1'b0;
        tick(); tick();
        chk("rst_dot", bus.dot, 0);
        chk("rst_ly", bus.ly, 0);
        chk("rst_mode", bus.ppu_mode, 0);
        chk("rst_stat_rd", bus.stat_rd, 8'h84);
        chk("rst_pulses", {bus.line_start, bus.irq_vblank, bus.irq_stat}, 0);
        reset = 1'b0;
        tick(); tick();
        chk("off_dot", bus.dot, 0);
        chk("off_mode", bus.ppu_mode, 0);

        // line 0: mode3_done at dot 252
        bus.lcd_en = 1'b1;
        tick();
        chk("en_ly", bus.ly, 0);
        chk("en_dot", bus.dot, 0);
        chk("en_mode", bus.ppu_mode, 2);
        chk("en_line_start", bus.line_start, 1);
        chk("en_stat_rd", bus.stat_rd, 8'h86);
        tick();
        chk("ls_one_cycle", bus.line_start, 0);
        run_to(0, 79);
        chk("mode_dot79", bus.ppu_mode, 2);
        tick();
        chk("mode_dot80", bus.ppu_mode, 3);
        run_to(0, 252);
        chk("mode_dot252", bus.ppu_mode, 3);
        bus.mode3_done = 1'b1;
        tick();
        bus.mode3_done = 1'b0;
        chk("dot253", bus.dot, 253);
        chk("mode_dot253", bus.ppu_mode, 0);
        run_to(0, 455);
        chk("mode_dot455", bus.ppu_mode, 0);
        tick();
        chk("wrap_ly", bus.ly, 1);
        chk("wrap_dot", bus.dot, 0);
        chk("wrap_mode", bus.ppu_mode, 2);
        chk("wrap_line_start", bus.line_start, 1);

        // line 1: mode3_done in mode 2 ignored, timeout ends mode 3
        run_to(1, 40);
        bus.mode3_done = 1'b1;
        tick();
        bus.mode3_done = 1'b0;
        chk("m3done_in_m2", bus.ppu_mode, 2);
        run_to(1, 368);
        chk("mode_dot368", bus.ppu_mode, 3);
        tick();
        chk("timeout_mode", bus.ppu_mode, 0);

        // VBlank entry and frame wrap
        run_to(143, 455);
        chk("ly143_mode", bus.ppu_mode, 0);
        tick();
        chk("vb_ly", bus.ly, 144);
        chk("vb_mode", bus.ppu_mode, 1);
        chk("vb_irq", bus.irq_vblank, 1);
        tick();
        chk("vb_irq_one", bus.irq_vblank, 0);
        chk("vb_mode_hold", bus.ppu_mode, 1);
        run_to(153, 455);
        chk("ly153_mode", bus.ppu_mode, 1);
        tick();
        chk("frame_ly", bus.ly, 0);
        chk("frame_mode", bus.ppu_mode, 2);
        chk("frame_vb_irq", bus.irq_vblank, 0);

        // LYC writes
        bus.lyc_wr = 1'b1; bus.lyc_wdata = 8'd5;
        tick();
        bus.lyc_wr = 1'b0;
        chk("lyc5_eq", bus.lyc_eq, 0);
        bus.stat_wr = 1'b1; bus.stat_wdata = 4'b1000;
        tick();
        bus.stat_wr = 1'b0;
        chk("stat_rd_c2", bus.stat_rd, 8'hC2);
        chk("no_irq_en_lyc", bus.irq_stat, 0);
        bus.lyc_wr = 1'b1; bus.lyc_wdata = 8'd0;
        #1;
        chk("lyc_wr_old", bus.irq_stat, 0);
        tick();
        bus.lyc_wr = 1'b0;
        chk("lyc_eq_new", bus.lyc_eq, 1);
        chk("lyc_irq", bus.irq_stat, 1);
        tick();
        chk("lyc_irq_one", bus.irq_stat, 0);

        // STAT blocking with en=1001, lyc=0
        bus.lcd_en = 1'b0;
        tick();
        bus.stat_wr = 1'b1; bus.stat_wdata = 4'b1001;
        tick();
        bus.stat_wr = 1'b0;
        chk("off_irq", bus.irq_stat, 0);
        bus.lcd_en = 1'b1;
        tick();
        chk("blk_mode", bus.ppu_mode, 2);
        chk("blk_irq_dot0", bus.irq_stat, 1);
        cnt = 0;
        for (int i = 0; i < 455; i++) begin
            tick();
            cnt += int'(bus.irq_stat);
        end
        chk("blk_line0_count", cnt, 0);
        run_to(1, 369);
        chk("ly1_hb_mode", bus.ppu_mode, 0);
        chk("ly1_hb_irq", bus.irq_stat, 1);

        // LCD off mid mode 3, then back on
        run_to(2, 100);
        chk("mid_m3", bus.ppu_mode, 3);
        bus.lcd_en = 1'b0;
        tick();
        chk("dis_ly", bus.ly, 0);
        chk("dis_dot", bus.dot, 0);
        chk("dis_mode", bus.ppu_mode, 0);
        chk("dis_pulses", {bus.line_start, bus.irq_vblank, bus.irq_stat}, 0);
        tick();
        chk("dis_hold", bus.dot, 0);
        bus.lcd_en = 1'b1;
        tick();
        chk("reen_mode", bus.ppu_mode, 2);
        chk("reen_ls", bus.line_start, 1);
        chk("reen_irq", bus.irq_stat, 1);

        // STAT write during HBLANK with line low
        bus.lyc_wr = 1'b1; bus.lyc_wdata = 8'd5;
        tick();
        bus.lyc_wr = 1'b0;
        bus.stat_wr = 1'b1; bus.stat_wdata = 4'b0000;
        tick();
        bus.stat_wr = 1'b0;
        run_to(0, 380);
        chk("bug_pre_mode", bus.ppu_mode, 0);
        chk("bug_pre_irq", bus.irq_stat, 0);
        bus.stat_wr = 1'b1; bus.stat_wdata = 4'b0000;
        #1;
        chk("bug_irq", bus.irq_stat, exp_bug);
        tick();
        bus.stat_wr = 1'b0;
        chk("bug_after", bus.irq_stat, 0);

        // reset mid-frame
        bus.stat_wr = 1'b1; bus.stat_wdata = 4'hF;
        tick();
        bus.stat_wr = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mrst_dot", bus.dot, 0);
        chk("mrst_mode", bus.ppu_mode, 0);
        chk("mrst_stat_rd", bus.stat_rd, 8'h84);
        chk("mrst_irq", bus.irq_stat, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_restart", bus.ppu_mode, 2);
        chk("mrst_ls", bus.line_start, 1);
        chk("mrst_no_irq", bus.irq_stat, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
